// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial pattern generator, MSB-first, with optional back-to-back looping
module seq_gen #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             loop,
  input  logic             stop,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               loop_q, loop_d;
  logic               stop_q, stop_d;
  logic               dout_d, valid_d, busy_d, done_d;
  logic [LEN_W-1:0]   len_eff;
  logic [WIDTH-1:0]   aligned;

  // Oversized lengths clamp to the register width; pattern is left-aligned so the MSB shifts out first.
  assign len_eff = (len > WIDTH_L) ? WIDTH_L : len;
  assign aligned = pattern << (WIDTH_L - len_eff);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    pat_d   = pat_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    loop_d  = loop_q;
    stop_d  = stop_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len_eff != '0)) begin
          state_d = SHIFT;
          sr_d    = aligned;
          pat_d   = aligned;
          len_d   = len_eff;
          cnt_d   = len_eff;
          loop_d  = loop;
          stop_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        dout_d  = sr_q[WIDTH-1];
        valid_d = 1'b1;
        busy_d  = 1'b1;
        sr_d    = sr_q << 1;
        cnt_d   = cnt_q - LEN_W'(1);
        stop_d  = stop_q | stop;
        if (cnt_q == LEN_W'(1)) begin
          done_d = 1'b1;
          // A stop seen on the last bit edge still ends the loop after this frame.
          if (loop_q && !(stop_q || stop)) begin
            sr_d  = pat_q;
            cnt_d = len_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      loop_q     <= 1'b0;
      stop_q     <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      loop_q     <= loop_d;
      stop_q     <= stop_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb/tb_seq_gen.sv - randomized self-checking bench for seq_gen against a bit-queue reference
module tb_seq_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pattern;
  logic [5:0]  len;
  logic        loop;
  logic        stop;
  logic        dout, dout_valid, busy, done;

  int checks = 0;
  int errors = 0;

  seq_gen #(.WIDTH(32), .LEN_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len),
    .loop(loop), .stop(stop), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Called just after a falling edge. stop_at / restart_at are bit-cycle indices (1-based) at
  // whose rising edge stop / start are sampled; 0 or out of range means never.
  task automatic frame(input logic [31:0] pat, input int l_in, input bit lp,
                       input int stop_at, input int restart_at, input bit chain);
    int L, nf, n;
    bit exp_q[$];
    L  = (l_in > 32) ? 32 : l_in;
    nf = 1;
    if (lp) nf = (stop_at - 1) / L + 1;
    n  = nf * L;
    for (int f = 0; f < nf; f++)
      for (int i = L - 1; i >= 0; i--) exp_q.push_back(pat[i]);

    start = 1'b1; pattern = pat; len = 6'(l_in); loop = lp; stop = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    pattern = $urandom; len = 6'($urandom_range(0, 63)); loop = 1'($urandom_range(0, 1));
    chk("lat_valid", dout_valid, 0);
    chk("lat_busy", busy, 1);
    chk("lat_dout", dout, 0);
    chk("lat_done", done, 0);

    for (int j = 1; j <= n; j++) begin
      stop  = (j == stop_at);
      start = (j == restart_at);
      @(negedge clk);
      chk("bit_dout", dout, exp_q[j-1]);
      chk("bit_valid", dout_valid, 1);
      chk("bit_busy", busy, 1);
      chk("bit_done", done, ((j % L) == 0));
    end
    stop = 1'b0; start = 1'b0;
    if (!chain) begin
      @(negedge clk);
      chk_idle("end");
    end
  endtask

  initial begin
    int l;
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; loop = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    frame(32'b10110, 5, 1'b0, 0, 3, 1'b0);
    frame(32'b1_0110_1_0110_1111_011, 17, 1'b0, 0, 0, 1'b0);
    frame(32'b101, 3, 1'b1, 5, 0, 1'b0);
    frame(32'hFFFF_FFFF, 40, 1'b0, 0, 32, 1'b0);

    start = 1'b1; len = 6'd0; pattern = $urandom;
    @(negedge clk);
    start = 1'b0;
    chk_idle("len0_a");
    @(negedge clk);
    chk_idle("len0_b");

    start = 1'b1; pattern = 32'hA5; len = 6'd8; loop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_idle("async_rst");
    @(negedge clk);
    chk_idle("rst_hold");
    rst = 1'b0;
    frame(32'hA5, 8, 1'b0, 0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      l = $urandom_range(1, 40);
      frame($urandom, l, 1'($urandom_range(0, 1)), $urandom_range(1, 3 * ((l > 32) ? 32 : l)),
            $urandom_range(0, (l > 32) ? 32 : l), (t != 29) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
